// File: rtl/sram_frame_reader_pkg.sv
// Shared types and helpers for the SRAM frame reader.
// Frame FSM encoding and frame-size arithmetic.
package sram_frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } frame_state_t;

  function automatic int unsigned frame_words(
    input int unsigned h,
    input int unsigned v
  );
    return h * v;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO; head word is always on dout.
// flush wins over push and pop in the same cycle.
module sync_fifo_fwft
  import sram_frame_reader_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          full;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage is not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= din;
    if (!reset && !flush && push)
      assert (!full);
  end

endmodule

// File: rtl/sram_frame_reader.sv
// Avalon-MM read master streaming one frame from SRAM to the
// pixel pipeline through a credit-protected show-ahead FIFO.
module sram_frame_reader
  import sram_frame_reader_pkg::*;
#(
  parameter int          AVN_AW     = 18,
  parameter int          AVN_DW     = 16,
  parameter int          H_PIXELS   = 640,
  parameter int          V_PIXELS   = 480,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic              avn_read,
  output logic [AVN_AW-1:0] avn_address,
  input  logic [AVN_DW-1:0] avn_readdata,
  input  logic              avn_readdatavalid,
  output logic              pix_valid,
  output logic [AVN_DW-1:0] pix_data,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              underflow
);

  localparam int WORDS = int'(frame_words(H_PIXELS, V_PIXELS));
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int SW    = CW + 2;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [IW-1:0]     LAST = IW'(WORDS - 1);
  localparam logic [AVN_AW-1:0] BASE = AVN_AW'(BASE_ADDR);

  frame_state_t  state;
  frame_state_t  state_nxt;

  logic [CW-1:0] in_flight;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] in_flight_nxt;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] pop_idx;
  logic [SW-1:0] credit_sum;

  logic          fifo_empty;
  logic          credit_ok;
  logic          issue;
  logic          rdv_ack;
  logic          push;
  logic          pop;
  logic          fetch_last;
  logic          drain_last;

  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;

  // The registered avn_read is a read already committed but not yet
  // seen by the controller, so it consumes a credit too.
  always_comb begin
    credit_sum = SW'(fifo_count) + SW'(in_flight)
               + SW'(avn_read) + SW'(1);
    credit_ok  = (credit_sum <= SW'(FIFO_DEPTH));
    issue      = (state == FETCH) && !frame_start && credit_ok;
    rdv_ack    = avn_readdatavalid && (in_flight != '0);
    push       = rdv_ack && (discard_cnt == '0) && !frame_start;
    fetch_last = issue && (rd_idx == LAST);
    drain_last = (state == DRAIN) && pop && (pop_idx == LAST)
               && !frame_start;
    in_flight_nxt = in_flight + CW'(avn_read) - CW'(rdv_ack);
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      frame_start: state_nxt = FETCH;
      fetch_last:  state_nxt = DRAIN;
      drain_last:  state_nxt = IDLE;
      default:     state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avn_read    <= 1'b0;
      avn_address <= BASE;
      in_flight   <= '0;
      discard_cnt <= '0;
      rd_idx      <= '0;
      pop_idx     <= '0;
      frame_done  <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      avn_read   <= issue;
      in_flight  <= in_flight_nxt;
      frame_done <= drain_last;
      underflow  <= pix_ready && !pix_valid && (state == FETCH);
      if (frame_start) begin
        avn_address <= BASE;
        rd_idx      <= '0;
        pop_idx     <= '0;
        // Everything still owed by the controller belongs to the old frame.
        discard_cnt <= in_flight_nxt;
      end else begin
        if (avn_read)
          avn_address <= avn_address + AVN_AW'(1);
        if (issue)
          rd_idx <= rd_idx + IW'(1);
        if (pop)
          pop_idx <= pop_idx + IW'(1);
        if (rdv_ack && (discard_cnt != '0))
          discard_cnt <= discard_cnt - CW'(1);
      end
    end
  end

  sync_fifo_fwft #(
    .DW    (AVN_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (frame_start),
    .push  (push),
    .din   (avn_readdata),
    .pop   (pop),
    .dout  (pix_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader with a 1-cycle SRAM model
// and address/pixel scoreboards.
module tb_sram_frame_reader;

  localparam int          AW    = 18;
  localparam int          DW    = 16;
  localparam int          H     = 4;
  localparam int          V     = 2;
  localparam int          DEPTH = 4;
  localparam int          WORDS = H * V;
  localparam logic [17:0] BASE  = 18'h3FFFC;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          avn_read;
  logic [AW-1:0] avn_address;
  logic [DW-1:0] rdata = '0;
  logic          rdv = 1'b0;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          frame_done;
  logic          underflow;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int uf_cnt = 0;

  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_pix[$];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  sram_frame_reader #(
    .AVN_AW     (AW),
    .AVN_DW     (DW),
    .H_PIXELS   (H),
    .V_PIXELS   (V),
    .BASE_ADDR  (32'h3FFFC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .frame_start       (frame_start),
    .avn_read          (avn_read),
    .avn_address       (avn_address),
    .avn_readdata      (rdata),
    .avn_readdatavalid (rdv),
    .pix_valid         (pix_valid),
    .pix_data          (pix_data),
    .pix_ready         (pix_ready),
    .frame_done        (frame_done),
    .underflow         (underflow)
  );

  // SRAM controller model: data one cycle after the read is sampled.
  always @(posedge clk) begin
    rdv   <= avn_read;
    rdata <= mem_f(avn_address);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (avn_read) begin
        rd_cnt++;
        checks++;
        assert (exp_addr.size() > 0) else begin
          errors++;
          $error("FAIL rd_unexp obs=%h exp=none", avn_address);
        end
        if (exp_addr.size() > 0) begin
          logic [AW-1:0] ea;
          ea = exp_addr.pop_front();
          checks++;
          assert (avn_address === ea) else begin
            errors++;
            $error("FAIL rd_addr obs=%h exp=%h", avn_address, ea);
          end
        end
      end
      if (pix_valid && pix_ready) begin
        pop_cnt++;
        checks++;
        assert (exp_pix.size() > 0) else begin
          errors++;
          $error("FAIL pix_unexp obs=%h exp=none", pix_data);
        end
        if (exp_pix.size() > 0) begin
          logic [DW-1:0] ep;
          ep = exp_pix.pop_front();
          checks++;
          assert (pix_data === ep) else begin
            errors++;
            $error("FAIL pix_data obs=%h exp=%h", pix_data, ep);
          end
        end
      end
      if (frame_done) begin
        done_cnt++;
        checks++;
        assert (pop_cnt === WORDS) else begin
          errors++;
          $error("FAIL done_pop obs=%0d exp=%0d", pop_cnt, WORDS);
        end
      end
      if (underflow)
        uf_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic restart_sb();
    exp_addr.delete();
    exp_pix.delete();
    for (int i = 0; i < WORDS; i++) begin
      logic [AW-1:0] a;
      a = BASE + AW'(i);
      exp_addr.push_back(a);
      exp_pix.push_back(mem_f(a));
    end
    rd_cnt  = 0;
    pop_cnt = 0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    restart_sb();
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 200) begin
      step();
      n++;
    end
    chk(tag, done_cnt, d0 + 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd"}, avn_read, 0);
    chk({tag, "_addr"}, avn_address, BASE);
    chk({tag, "_pv"}, pix_valid, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_uf"}, underflow, 0);
  endtask

  initial begin
    int u0;
    logic pv_seen;
    reset       = 1'b1;
    frame_start = 1'b0;
    pix_ready   = 1'b0;
    repeat (3) step();
    chk_reset_outs("rst");
    reset = 1'b0;

    // Ready high while idle: no underflow outside FETCH.
    pix_ready = 1'b1;
    repeat (5) step();
    chk("idle_uf", uf_cnt, 0);

    // Frame 1: full-rate streaming, address wrap, first-data timing.
    u0 = uf_cnt;
    pulse_start();
    chk("k0_rd", avn_read, 0);
    step();
    chk("k1_rd", avn_read, 1);
    chk("k1_addr", avn_address, BASE);
    step();
    chk("k2_pv", pix_valid, 0);
    step();
    chk("k3_pv", pix_valid, 1);
    chk("k3_pix", pix_data, mem_f(BASE));
    wait_done("f1_done");
    repeat (5) step();
    chk("f1_done_once", done_cnt, 1);
    chk("f1_uf", uf_cnt - u0, 3);
    chk("f1_addr_left", exp_addr.size(), 0);
    chk("f1_pix_left", exp_pix.size(), 0);

    // Frame 2: consumer stalled, credit limit caps reads at DEPTH.
    pix_ready = 1'b0;
    pulse_start();
    repeat (20) step();
    chk("st_reads", rd_cnt, DEPTH);
    chk("st_rd_low", avn_read, 0);
    chk("st_pv", pix_valid, 1);
    chk("st_head", pix_data, mem_f(BASE));
    pix_ready = 1'b1;
    wait_done("st_done");
    repeat (3) step();
    chk("st_reads_all", rd_cnt, WORDS);
    chk("st_pix_left", exp_pix.size(), 0);
    chk("st_done_cnt", done_cnt, 2);

    // Frame 3: restart while a read is outstanding.
    pulse_start();
    step();
    step();
    chk("rs_pending", avn_read, 1);
    pulse_start();
    chk("rs_k0_rd", avn_read, 0);
    step();
    chk("rs_k1_rd", avn_read, 1);
    chk("rs_k1_addr", avn_address, BASE);
    step();
    step();
    chk("rs_first_pv", pix_valid, 1);
    chk("rs_first_pix", pix_data, mem_f(BASE));
    wait_done("rs_done");
    repeat (3) step();
    chk("rs_pix_left", exp_pix.size(), 0);
    chk("rs_done_cnt", done_cnt, 3);

    // Frame 4: reset mid-frame; the late return must not surface.
    pulse_start();
    step();
    step();
    chk("mr_pending", avn_read, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_addr.delete();
    exp_pix.delete();
    chk_reset_outs("mr");
    pv_seen = 1'b0;
    repeat (6) begin
      if (pix_valid)
        pv_seen = 1'b1;
      step();
    end
    chk("mr_no_pix", pv_seen, 0);
    chk("mr_done_cnt", done_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
